relay_nibble_rx: RTL and testbench

//  - Deserialises the inter-Proxmark relay line into 4-bit nibbles with a 1-cycle valid strobe.
//  - Sits directly upstream of the relay mode-switching stage.
//  - data_out/data_available feed that stage's data_in/data_in_available.
//  - Remote side shifts one bit per BIT_CLKS clocks.
//  - Frame: line idles high; start bit (low); 4 data bits MSB first; 1 stop bit (high).

---
 rtl/relay_nibble_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_relay_nibble_rx.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_nibble_rx.sv
// ---------------------------------------------------------------------------
// relay_nibble_rx
//
// Purpose
//   Deserialises the inter-Proxmark relay line into 4-bit nibbles. The remote
//   unit shifts one bit every BIT_CLKS clocks. A frame is: the line idling
//   high, one start bit (low), four data bits (MSB first) and one stop bit
//   (high). A correctly framed nibble is presented on data_out with a
//   one-cycle data_available strobe. data_out/data_available feed the relay
//   mode-switching stage's data_in/data_in_available.
//
// Ports
//   clk             in   system clock, all state on its rising edge
//   rst_n           in   asynchronous active-low reset
//   enable          in   high only in the FAKE_READER / FAKE_TAG relay modes
//   relay_rx        in   raw asynchronous relay line from the remote unit
//   data_out        out  [3:0] last correctly framed nibble (MSB = first bit)
//   data_available  out  one-cycle pulse, data_out updated this cycle
//   frame_err       out  one-cycle pulse, stop bit was sampled low
//   busy            out  high while a frame is in progress (state != IDLE)
//
// Parameters
//   BIT_CLKS  clocks per relay bit (even, >= 4)
//   CNT_W     bit-timing counter width, must hold BIT_CLKS-1
//
// Build option
//   RELAY_RX_GLITCH_FILTER_EN : when defined, the synchronised line passes
//   through a registered majority-of-3 filter. This adds one clock of
//   pin-to-rx_s latency and rejects single-cycle pulses on relay_rx. Frame
//   timing relative to rx_s is the same in both builds.
// ---------------------------------------------------------------------------
module relay_nibble_rx #(
    parameter int BIT_CLKS = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       relay_rx,
    output logic [3:0] data_out,
    output logic       data_available,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Sample points: middle of the start bit, then one full bit period later
    // for every following bit, which lands each sample mid-bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);

    // -----------------------------------------------------------------------
    // Input path: two-flop synchroniser (reset to the idle-high level so a
    // reset never looks like a start bit).
    // -----------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= relay_rx;
            sync2_q <= sync1_q;
        end
    end

`ifdef RELAY_RX_GLITCH_FILTER_EN
    // Majority vote over three consecutive synchronised samples. A one-cycle
    // pulse only ever occupies one of the three taps, so it never wins.
    // The vote is registered, giving one extra clock of latency.
    logic hist_q;
    logic filt_q;
    logic filt_d;

    always_comb begin
        filt_d = (sync1_q & sync2_q) | (sync1_q & hist_q) | (sync2_q & hist_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= sync2_q;
            filt_q <= filt_d;
        end
    end

    assign rx_s = filt_q;
`else
    assign rx_s = sync2_q;
`endif

    // -----------------------------------------------------------------------
    // Frame FSM state
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       bitidx_q;
    logic [1:0]       bitidx_d;
    logic [3:0]       shreg_q;
    logic [3:0]       shreg_d;
    logic [3:0]       data_out_q;
    logic [3:0]       data_out_d;
    logic             dav_q;
    logic             dav_d;
    logic             ferr_q;
    logic             ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitidx_q   <= 2'd0;
            shreg_q    <= 4'h0;
            data_out_q <= 4'h0;
            dav_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitidx_q   <= bitidx_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            dav_q      <= dav_d;
            ferr_q     <= ferr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitidx_d   = bitidx_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        dav_d      = 1'b0;
        ferr_d     = 1'b0;

        if (!enable) begin
            // Leaving the relay modes abandons any partial nibble silently;
            // the last good nibble stays on data_out.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = START;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            // Line back high at mid start bit: a glitch,
                            // not a frame. Dropped without an error pulse.
                            state_d = IDLE;
                        end else begin
                            state_d  = DATA;
                            bitidx_d = 2'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d    = '0;
                        // MSB arrives first, so shifting in at the LSB leaves
                        // the first bit in shreg[3] after four samples.
                        shreg_d  = {shreg_q[2:0], rx_s};
                        bitidx_d = bitidx_q + 2'd1;
                        if (bitidx_q == 2'd3) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            data_out_d = shreg_q;
                            dav_d      = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                WAIT_IDLE: begin
                    // After a bad stop bit the line may be stuck low; wait
                    // for it to go high so a low level is not taken as a
                    // fresh start bit.
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign data_available = dav_q;
    assign frame_err      = ferr_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_relay_nibble_rx.sv
// ---------------------------------------------------------------------------
// tb_relay_nibble_rx
//
// Table-driven frame vectors, hand-written multi-cycle sequences (back-to-back
// frames, glitches, enable drop, mid-frame reset) and a randomized phase
// checked against a waveform-level reference model. Every cycle's line,
// enable and DUT outputs are recorded; expected events are derived from the
// recorded line using the frame sampling rules.
// ---------------------------------------------------------------------------
module tb_relay_nibble_rx;

    localparam int BC   = 16;
    localparam int MAXC = 16384;
`ifdef RELAY_RX_GLITCH_FILTER_EN
    localparam int LAT = 4;   // line change after edge s is first seen by the FSM at edge s+LAT
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       relay_rx;
    logic [3:0] data_out;
    logic       data_available;
    logic       frame_err;
    logic       busy;

    relay_nibble_rx #(.BIT_CLKS(BC), .CNT_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .relay_rx       (relay_rx),
        .data_out       (data_out),
        .data_available (data_available),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Recorded waveform: index n = value present after rising edge n.
    logic       rec_in [MAXC];
    logic       rec_en [MAXC];
    logic       o_dav  [MAXC];
    logic       o_ferr [MAXC];
    logic       o_busy [MAXC];
    logic [3:0] o_dout [MAXC];
    bit         exp_dav [MAXC];
    bit         exp_ferr[MAXC];
    logic [3:0] exp_nib [MAXC];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            rec_in[cyc] <= relay_rx;
            rec_en[cyc] <= enable;
            o_dav[cyc]  <= data_available;
            o_ferr[cyc] <= frame_err;
            o_busy[cyc] <= busy;
            o_dout[cyc] <= data_out;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_const(input logic b, input int n);
        relay_rx = b;
        repeat (n) tick();
    endtask

    task automatic drive_frame(input logic [3:0] nib, input logic stop, input int stop_len);
        drive_const(1'b0, BC);
        for (int i = 3; i >= 0; i--) drive_const(nib[i], BC);
        drive_const(stop, stop_len);
    endtask

    function automatic int count_dav(input int a, input int b);
        int c = 0;
        for (int n = a; n < b; n++) c += int'(o_dav[n]);
        return c;
    endfunction

    function automatic int count_ferr(input int a, input int b);
        int c = 0;
        for (int n = a; n < b; n++) c += int'(o_ferr[n]);
        return c;
    endfunction

    function automatic int count_busy(input int a, input int b);
        int c = 0;
        for (int n = a; n < b; n++) c += int'(o_busy[n]);
        return c;
    endfunction

    // ---------------- reference model ----------------
    // Line level seen by the frame logic at edge m.
    function automatic bit rxs(input int m);
`ifdef RELAY_RX_GLITCH_FILTER_EN
        return (int'(rec_in[m-3]) + int'(rec_in[m-4]) + int'(rec_in[m-5])) >= 2;
`else
        return rec_in[m-3];
`endif
    endfunction

    function automatic bit en_at(input int m);
        return rec_en[m-1];
    endfunction

    // Scan the recorded line: a frame starts at the first enabled edge E0 that
    // sees the line low; samples at E0+8, +24, +40, +56, +72, stop at +88.
    // Any disabled edge inside the frame abandons it.
    task automatic run_model(input int w0, input int w1);
        int m;
        int e0;
        int ab;
        logic [3:0] nib;
        for (int n = w0; n < w1; n++) begin
            exp_dav[n]  = 0;
            exp_ferr[n] = 0;
            exp_nib[n]  = 4'h0;
        end
        m = w0;
        while (m < w1 - 100) begin
            if (!en_at(m) || rxs(m)) begin
                m++;
                continue;
            end
            e0 = m;
            ab = -1;
            for (int t = e0 + 1; t <= e0 + BC/2 + 5*BC; t++) begin
                if (!en_at(t)) begin
                    ab = t;
                    break;
                end
            end
            if (ab >= 0 && ab <= e0 + BC/2) begin
                m = ab + 1;
                continue;
            end
            if (rxs(e0 + BC/2)) begin
                m = e0 + BC/2 + 1;
                continue;
            end
            if (ab >= 0) begin
                m = ab + 1;
                continue;
            end
            for (int i = 0; i < 4; i++) nib[3-i] = rxs(e0 + BC/2 + BC*(i+1));
            if (rxs(e0 + BC/2 + 5*BC)) begin
                exp_dav[e0 + BC/2 + 5*BC] = 1;
                exp_nib[e0 + BC/2 + 5*BC] = nib;
                m = e0 + BC/2 + 5*BC + 1;
            end else begin
                exp_ferr[e0 + BC/2 + 5*BC] = 1;
                m = e0 + BC/2 + 5*BC + 1;
                while (m < w1 && en_at(m) && !rxs(m)) m++;
                m++;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] nib;
        logic       stop_ok;
        int         exp_dav;
        int         exp_ferr;
        logic [3:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int e;
        int p0;
        int w0;
        int w1;
        int r;
        int p;
        int q;
        logic [3:0] nib;
        logic [3:0] cur;

        vecs[0] = '{4'hC, 1'b1, 1, 0, 4'hC};
        vecs[1] = '{4'hA, 1'b0, 0, 1, 4'hC};
        vecs[2] = '{4'h5, 1'b1, 1, 0, 4'h5};
        vecs[3] = '{4'h0, 1'b1, 1, 0, 4'h0};
        vecs[4] = '{4'hF, 1'b1, 1, 0, 4'hF};
        vecs[5] = '{4'h6, 1'b0, 0, 1, 4'hF};

        relay_rx = 1'b1;
        enable   = 1'b1;
        rst_n    = 1'b0;
        repeat (4) tick();
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_dav", int'(data_available), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        drive_const(1'b1, 20);

        // ---- table-driven frames ----
        for (int v = 0; v < 6; v++) begin
            s = cyc;
            if (vecs[v].stop_ok) begin
                drive_frame(vecs[v].nib, 1'b1, BC);
                drive_const(1'b1, 30);
                chk($sformatf("vec%0d_pulse_time", v), int'(o_dav[s+LAT+88]), 1);
            end else begin
                drive_frame(vecs[v].nib, 1'b0, BC);
                drive_const(1'b0, 50);
                chk($sformatf("vec%0d_busy_while_low", v), int'(o_busy[cyc-1]), 1);
                drive_const(1'b1, 30);
            end
            chk($sformatf("vec%0d_dav_count", v), count_dav(s, cyc), vecs[v].exp_dav);
            chk($sformatf("vec%0d_ferr_count", v), count_ferr(s, cyc), vecs[v].exp_ferr);
            chk($sformatf("vec%0d_data_out", v), int'(o_dout[cyc-1]), int'(vecs[v].exp_dout));
            chk($sformatf("vec%0d_busy_end", v), int'(o_busy[cyc-1]), 0);
            $display("vec %0d nibble=%h stop_ok=%0d data_out=%h", v, vecs[v].nib,
                     vecs[v].stop_ok, o_dout[cyc-1]);
        end

        // ---- back-to-back at minimum spacing: next start accepted at E0+89 ----
        s = cyc;
        drive_frame(4'hF, 1'b1, 9);
        drive_frame(4'h0, 1'b1, 9);
        drive_frame(4'h0, 1'b1, BC);
        drive_const(1'b1, 20);
        p0 = s + LAT + 88;
        chk("b2b_pulse0", int'(o_dav[p0]), 1);
        chk("b2b_dout0", int'(o_dout[p0]), 'hF);
        chk("b2b_pulse1", int'(o_dav[p0+89]), 1);
        chk("b2b_dout1", int'(o_dout[p0+89]), 0);
        chk("b2b_pulse2", int'(o_dav[p0+178]), 1);
        chk("b2b_count", count_dav(s, cyc), 3);
        $display("b2b frames F,0,0 pulses at %0d %0d %0d", p0, p0 + 89, p0 + 178);

        // ---- 3-clock glitch on idle line ----
        s = cyc;
        drive_const(1'b0, 3);
        drive_const(1'b1, 20);
        chk("glitch3_busy_rises", int'(o_busy[s+LAT]), 1);
        chk("glitch3_busy_falls", int'(o_busy[s+13]), 0);
        chk("glitch3_dav", count_dav(s, cyc), 0);
        chk("glitch3_ferr", count_ferr(s, cyc), 0);
        $display("glitch 3clk at cycle %0d", s);
`ifdef RELAY_RX_GLITCH_FILTER_EN
        s = cyc;
        drive_const(1'b0, 1);
        drive_const(1'b1, 20);
        chk("glitch1_busy_never", count_busy(s, cyc), 0);
        $display("glitch 1clk at cycle %0d", s);
`endif

        // ---- enable dropped during bit 2 of nibble 5 ----
        s = cyc;
        drive_const(1'b0, BC);
        drive_const(1'b0, BC);
        drive_const(1'b1, BC/2);
        enable = 1'b0;
        e = cyc;
        drive_const(1'b1, BC/2);
        drive_const(1'b0, BC);
        drive_const(1'b1, BC);
        drive_const(1'b1, BC);
        enable = 1'b1;
        drive_const(1'b1, 20);
        chk("endrop_busy_before", int'(o_busy[e]), 1);
        chk("endrop_busy_after", int'(o_busy[e+1]), 0);
        chk("endrop_dav", count_dav(s, cyc), 0);
        chk("endrop_dout_kept", int'(o_dout[cyc-1]), 0);
        s = cyc;
        drive_frame(4'h3, 1'b1, BC);
        drive_const(1'b1, 20);
        chk("after_endrop_pulse", int'(o_dav[s+LAT+88]), 1);
        chk("after_endrop_dout", int'(o_dout[cyc-1]), 3);
        $display("enable drop at cycle %0d, then nibble 3", e);

        // ---- async reset mid-frame ----
        drive_const(1'b0, BC);
        drive_const(1'b0, BC);
        drive_const(1'b1, BC/2);
        chk("midreset_busy_before", int'(o_busy[cyc-1]), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_data_out", int'(data_out), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_dav", int'(data_available), 0);
        chk("midreset_ferr", int'(frame_err), 0);
        relay_rx = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        drive_const(1'b1, 20);
        s = cyc;
        drive_frame(4'h9, 1'b1, BC);
        drive_const(1'b1, 20);
        chk("after_reset_pulse", int'(o_dav[s+LAT+88]), 1);
        chk("after_reset_dout", int'(o_dout[cyc-1]), 9);
        chk("after_reset_count", count_dav(s, cyc), 1);
        $display("mid-frame reset, then nibble 9");

        // ---- randomized phase against the reference model ----
        w0 = cyc;
        for (int k = 0; k < 40; k++) begin
            r   = $urandom_range(0, 99);
            nib = 4'($urandom_range(0, 15));
            $display("rand frame %0d kind=%0d nibble=%h start=%0d", k, r, nib, cyc);
            if (r < 65) begin
                drive_frame(nib, 1'b1, $urandom_range(9, BC));
                drive_const(1'b1, $urandom_range(0, 10));
            end else if (r < 77) begin
                drive_frame(nib, 1'b0, BC);
                drive_const(1'b0, $urandom_range(0, 20));
                drive_const(1'b1, $urandom_range(1, 10));
            end else if (r < 89) begin
                drive_const(1'b0, $urandom_range(1, 6));
                drive_const(1'b1, $urandom_range(12, 20));
            end else begin
                p = $urandom_range(0, 63);
                q = $urandom_range(1, 20);
                drive_const(1'b0, BC);
                for (int c = 0; c < 4*BC; c++) begin
                    relay_rx = nib[3 - c/BC];
                    enable   = (c >= p && c < p + q) ? 1'b0 : 1'b1;
                    tick();
                end
                enable = 1'b1;
                drive_const(1'b1, BC);
                drive_const(1'b1, $urandom_range(0, 10));
            end
        end
        drive_const(1'b1, 120);
        w1 = cyc;

        run_model(w0, w1);
        cur = 4'h9;
        for (int n = w0; n < w1; n++) begin
            if (exp_dav[n]) cur = exp_nib[n];
            if (exp_dav[n] || o_dav[n]) begin
                chk($sformatf("rand_dav@%0d", n), int'(o_dav[n]), int'(exp_dav[n]));
                chk($sformatf("rand_dout@%0d", n), int'(o_dout[n]), int'(cur));
            end
            if (exp_ferr[n] || o_ferr[n]) begin
                chk($sformatf("rand_ferr@%0d", n), int'(o_ferr[n]), int'(exp_ferr[n]));
            end
        end
        chk("rand_final_dout", int'(o_dout[w1-1]), int'(cur));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
